dsp_cfg_loader: RTL and testbench

- Serial configuration controller for the DSP pattern-detection stage's 100-bit configuration chain: PATTERN[48], SEL_PATTERN, SEL_MASK[2], PREG and MASK[48].
- Accepts one parallel configuration word through a valid/ready handshake, then drives configuration_input/configuration_enable for exactly CHAIN_LEN cycles.
- Sits between the fabric configuration bus and one pattern-detection instance. Optionally runs a read-back pass that checks the chain contents through configuration_output.

---
 rtl/dsp_cfg_loader.sv | 144 ++++++++++++++
 tb/tb_dsp_cfg_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_cfg_loader.sv
// Serial loader for the 100-bit DSP pattern-detect configuration chain, fed by a valid/ready config word.
// Optional read-back check of the chain tail is enabled with `define DSP_CFG_VERIFY_EN.
module dsp_cfg_loader #(
  parameter int CHAIN_LEN = 100,
  parameter int CNT_W     = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CHAIN_LEN-1:0] cfg_data,
  input  logic                 cfg_abort,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  output logic                 cfg_err,
  output logic                 configuration_input,
  output logic                 configuration_enable,
  input  logic                 configuration_output
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
`ifdef DSP_CFG_VERIFY_EN
    S_VERIFY = 2'd3,
`endif
    S_DONE   = 2'd2
  } state_t;

  state_t               state;
  logic [CHAIN_LEN-1:0] shadow;
  logic [CNT_W-1:0]     counter;
  logic [CNT_W-1:0]     cur_idx;
  logic [CNT_W-1:0]     nxt_idx;

  // counter tracks the bit currently on configuration_input, MSB first
  assign cur_idx = LAST - counter;
  assign nxt_idx = cur_idx - CNT_W'(1);

`ifdef DSP_CFG_VERIFY_EN
  logic verify_fail;
  logic mismatch;
  // re-shifting the same image means the tail must equal the bit now being driven
  assign mismatch = configuration_output != shadow[cur_idx];
`else
  logic unused_cfg_out;
  assign unused_cfg_out = configuration_output;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= S_IDLE;
      shadow               <= '0;
      counter              <= '0;
      cfg_ready            <= 1'b1;
      cfg_busy             <= 1'b0;
      cfg_done             <= 1'b0;
      cfg_err              <= 1'b0;
      configuration_enable <= 1'b0;
      configuration_input  <= 1'b0;
`ifdef DSP_CFG_VERIFY_EN
      verify_fail          <= 1'b0;
`endif
    end else begin
      cfg_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_valid && cfg_ready) begin
            shadow               <= cfg_data;
            counter              <= '0;
            cfg_err              <= 1'b0;
            cfg_ready            <= 1'b0;
            cfg_busy             <= 1'b1;
            configuration_enable <= 1'b1;
            configuration_input  <= cfg_data[CHAIN_LEN-1];
            state                <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cfg_abort) begin
            cfg_err              <= 1'b1;
            cfg_ready            <= 1'b1;
            cfg_busy             <= 1'b0;
            configuration_enable <= 1'b0;
            configuration_input  <= 1'b0;
            state                <= S_IDLE;
          end else if (counter == LAST) begin
`ifdef DSP_CFG_VERIFY_EN
            counter             <= '0;
            configuration_input <= shadow[LAST];
            verify_fail         <= 1'b0;
            state               <= S_VERIFY;
`else
            cfg_done             <= 1'b1;
            cfg_busy             <= 1'b0;
            configuration_enable <= 1'b0;
            configuration_input  <= 1'b0;
            state                <= S_DONE;
`endif
          end else begin
            counter             <= counter + CNT_W'(1);
            configuration_input <= shadow[nxt_idx];
          end
        end
`ifdef DSP_CFG_VERIFY_EN
        S_VERIFY: begin
          if (cfg_abort || (counter == LAST && (verify_fail || mismatch))) begin
            cfg_err              <= 1'b1;
            cfg_ready            <= 1'b1;
            cfg_busy             <= 1'b0;
            configuration_enable <= 1'b0;
            configuration_input  <= 1'b0;
            state                <= S_IDLE;
          end else if (counter == LAST) begin
            cfg_done             <= 1'b1;
            cfg_busy             <= 1'b0;
            configuration_enable <= 1'b0;
            configuration_input  <= 1'b0;
            state                <= S_DONE;
          end else begin
            counter             <= counter + CNT_W'(1);
            configuration_input <= shadow[nxt_idx];
            verify_fail         <= verify_fail | mismatch;
          end
        end
`endif
        S_DONE: begin
          cfg_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          cfg_ready            <= 1'b1;
          cfg_busy             <= 1'b0;
          configuration_enable <= 1'b0;
          configuration_input  <= 1'b0;
          state                <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_cfg_loader.sv
// Directed + randomized bench for dsp_cfg_loader against a behavioural chain model.
module tb_dsp_cfg_loader;

  localparam int CL = 100;
`ifdef DSP_CFG_VERIFY_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int EN_TOT = CL * PASSES;   // enabled cycles per successful load
  localparam int LAT    = EN_TOT + 1;    // handshake edge to done cycle
  localparam int PERIOD = LAT + 1;       // back-to-back acceptance spacing

  logic          clk;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CL-1:0] cfg_data;
  logic          cfg_abort;
  logic          cfg_busy;
  logic          cfg_done;
  logic          cfg_err;
  logic          configuration_input;
  logic          configuration_enable;
  logic          configuration_output;

  // behavioural pattern-detect chain: input enters position 0, tail is position CL-1
  logic [CL-1:0] chain;
  int            stuck_bit;

  int n_cmp, n_err;
  int cyc, en_cnt, done_cnt, done_cyc, ones_cnt, rdy_viol;
  logic first_bit, last_bit;

  assign configuration_output = chain[CL-1];

  dsp_cfg_loader #(.CHAIN_LEN(CL), .CNT_W(7)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cfg_valid            (cfg_valid),
    .cfg_ready            (cfg_ready),
    .cfg_data             (cfg_data),
    .cfg_abort            (cfg_abort),
    .cfg_busy             (cfg_busy),
    .cfg_done             (cfg_done),
    .cfg_err              (cfg_err),
    .configuration_input  (configuration_input),
    .configuration_enable (configuration_enable),
    .configuration_output (configuration_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; en_cnt = 0; done_cnt = 0; done_cyc = -1; ones_cnt = 0; rdy_viol = 0;
    first_bit = 1'b0; last_bit = 1'b0;
  endtask

  task automatic tick();
    logic en_pre, din_pre;
    en_pre  = configuration_enable;
    din_pre = configuration_input;
    @(posedge clk);
    #2;
    if (en_pre) begin
      chain = {chain[CL-2:0], din_pre};
      if (stuck_bit >= 0) chain[stuck_bit] = 1'b0;
    end
    cyc++;
    if (configuration_enable) begin
      en_cnt++;
      if (configuration_input) ones_cnt++;
      if (en_cnt == 1) first_bit = configuration_input;
      last_bit = configuration_input;
    end
    if (cfg_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (cfg_busy && cfg_ready) rdy_viol++;
  endtask

  task automatic start(input logic [CL-1:0] d);
    cfg_data  = d;
    cfg_valid = 1'b1;
    clear_stats();
    tick();
    cfg_valid = 1'b0;
    cfg_data  = {4{$urandom}};
  endtask

  task automatic full_load(input string tag, input logic [CL-1:0] d);
    start(d);
    repeat (LAT + 3) tick();
    chk({tag, "_en_cycles"}, en_cnt, EN_TOT);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_cyc"}, done_cyc, LAT);
    chk({tag, "_err"}, cfg_err, 1'b0);
    chk({tag, "_chain"}, chain, d);
    chk({tag, "_rdy_busy"}, rdy_viol, 0);
  endtask

  initial begin
    logic [CL-1:0] d;
    logic [47:0]   pat, msk;
    logic [1:0]    selm;
    logic [CL-1:0] words [3*PERIOD];
    int            nload;

    n_cmp = 0; n_err = 0; stuck_bit = -1; chain = '0;
    rst = 1'b1; cfg_valid = 1'b0; cfg_abort = 1'b0; cfg_data = '0;
    clear_stats();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", cfg_ready, 1'b1);
    chk("rst_busy", cfg_busy, 1'b0);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    chk("rst_en", configuration_enable, 1'b0);
    chk("rst_in", configuration_input, 1'b0);
    rst = 1'b0;
    tick();

    // corner bits: only first and last shifted bits are 1
    d = '0; d[CL-1] = 1'b1; d[0] = 1'b1;
    full_load("edge", d);
    chk("edge_first", first_bit, 1'b1);
    chk("edge_last", last_bit, 1'b1);
    chk("edge_ones", ones_cnt, 2 * PASSES);

    // field layout as seen by the pattern-detect registers
    pat = 48'hA5A5_0000_FFFF; msk = 48'h1234_5678_9ABC; selm = 2'b10;
    full_load("fields", {msk, 1'b1, selm, 1'b1, pat});
    chk("fld_pattern", chain[47:0], pat);
    chk("fld_sel_pattern", chain[48], 1'b1);
    chk("fld_sel_mask", chain[50:49], selm);
    chk("fld_preg", chain[51], 1'b1);
    chk("fld_mask", chain[99:52], msk);

    for (int i = 0; i < 3; i++) full_load("rand", {4{$urandom}});

    // abort on the 40th enabled cycle
    start({4{$urandom}});
    while (en_cnt < 40 && cyc < 300) tick();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    chk("abort_en", configuration_enable, 1'b0);
    chk("abort_err", cfg_err, 1'b1);
    chk("abort_ready", cfg_ready, 1'b1);
    chk("abort_busy", cfg_busy, 1'b0);
    repeat (LAT) tick();
    chk("abort_no_done", done_cnt, 0);
    chk("abort_en_cnt", en_cnt, 40);
    start({4{$urandom}});
    chk("reload_err_clr", cfg_err, 1'b0);
    chk("reload_en", configuration_enable, 1'b1);
    repeat (LAT + 2) tick();
    chk("reload_done", done_cnt, 1);

    // abort coinciding with the final enabled cycle
    start({4{$urandom}});
    while (en_cnt < EN_TOT && cyc < 400) tick();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    repeat (3) tick();
    chk("abort_last_err", cfg_err, 1'b1);
    chk("abort_last_done", done_cnt, 0);

    // valid held high with a new word every cycle
    for (int c = 0; c < 3 * PERIOD; c++) words[c] = {4{$urandom}};
    clear_stats();
    nload = 0;
    cfg_valid = 1'b1;
    for (int c = 0; c < 3 * PERIOD; c++) begin
      cfg_data = words[c];
      tick();
      if (cfg_done) begin
        chk("stream_word", chain, (nload < 3) ? words[nload * PERIOD] : '0);
        nload++;
      end
    end
    cfg_valid = 1'b0;
    repeat (LAT + 2) tick();
    chk("stream_loads", nload, 3);
    chk("stream_rdy_busy", rdy_viol, 0);

    // asynchronous reset in the 50th enabled cycle
    start({4{$urandom}});
    while (en_cnt < 50 && cyc < 300) tick();
    #3 rst = 1'b1;
    #1;
    chk("mrst_en", configuration_enable, 1'b0);
    chk("mrst_ready", cfg_ready, 1'b1);
    chk("mrst_busy", cfg_busy, 1'b0);
    chk("mrst_err", cfg_err, 1'b0);
    chk("mrst_done", cfg_done, 1'b0);
    #2 rst = 1'b0;
    tick();
    chk("mrst_idle_en", configuration_enable, 1'b0);
    full_load("after_rst", {4{$urandom}});

`ifdef DSP_CFG_VERIFY_EN
    stuck_bit = 60;
    d = {4{$urandom}}; d[60] = 1'b1;
    start(d);
    repeat (LAT + 3) tick();
    chk("vfy_stuck_err", cfg_err, 1'b1);
    chk("vfy_stuck_done", done_cnt, 0);
    chk("vfy_stuck_en", en_cnt, EN_TOT);
    stuck_bit = -1;
    full_load("vfy_clean", {4{$urandom}});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
